mem_io_bridge: RTL

Data-memory and memory-mapped I/O bridge sitting directly downstream of the multicycle controller and datapath. Decodes the 16-bit memory address, steers accesses to an external single-port block RAM or to on-chip I/O registers (LED output, debounced switch input, 32-bit cycle timer), and returns read data with the fixed one-cycle latency that the load sequence expects: address in LB_MEM, data captured in LB_LOAD.

---
 rtl/mem_io_bridge.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_io_bridge.sv
// Data-memory / memory-mapped I/O bridge: RAM vs I/O decode, LED and debounced switch
// registers, one-cycle read path. Optional 32-bit cycle timer is built when MMIO_TIMER_EN is defined.
module mem_io_bridge #(
    parameter int DATA_W       = 16,
    parameter int RAM_AW       = 14,
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [15:0]       sw_in,
    output logic [15:0]       led_out
);

    localparam logic [15:0] ADDR_LED     = 16'hFFF0;
    localparam logic [15:0] ADDR_SW      = 16'hFFF1;
    localparam logic [15:0] ADDR_TMR_LO  = 16'hFFF2;
    localparam logic [15:0] ADDR_TMR_HI  = 16'hFFF3;
    localparam logic [15:0] ADDR_TMR_CTL = 16'hFFF4;

    localparam int               DEB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);

    logic              ram_sel;
    logic              sel_ram_reg;
    logic [DATA_W-1:0] io_value;
    logic [DATA_W-1:0] io_q_reg;
    logic [15:0]       led_reg;
    logic [15:0]       sync1_reg;
    logic [15:0]       sync2_reg;
    logic [15:0]       sw_stable_reg;
    logic [DEB_W-1:0]  deb_cnt_reg;
    logic [15:0]       tmr_lo_val;
    logic [15:0]       tmr_hi_val;
    logic [15:0]       tmr_ctl_val;

    assign ram_sel   = (addr[15:12] != 4'hF);
    assign ram_addr  = addr[RAM_AW-1:0];
    assign ram_wdata = wr_data;
    assign ram_we    = wr_en & ram_sel;
    assign led_out   = led_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            led_reg <= '0;
        end else if (wr_en && addr == ADDR_LED) begin
            led_reg <= wr_data[15:0];
        end
    end

    // Switch synchronizer and debounce: a new synced value must hold for DEBOUNCE_CYC cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg     <= '0;
            sync2_reg     <= '0;
            sw_stable_reg <= '0;
            deb_cnt_reg   <= '0;
        end else begin
            sync1_reg <= sw_in;
            sync2_reg <= sync1_reg;
            if (sync2_reg != sw_stable_reg && deb_cnt_reg == DEB_LAST) begin
                sw_stable_reg <= sync2_reg;
                deb_cnt_reg   <= '0;
            end else if (sync1_reg != sync2_reg || sync2_reg == sw_stable_reg) begin
                deb_cnt_reg <= '0;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
            end
        end
    end

`ifdef MMIO_TIMER_EN
    logic        run_reg;
    logic [31:0] tmr_reg;
    logic [15:0] hi_snap_reg;
    logic        ctl_wr;

    assign ctl_wr = wr_en && (addr == ADDR_TMR_CTL);

    // Clear beats increment; hi_snap samples the same counter value that TMR_LO returns.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_reg     <= 1'b0;
            tmr_reg     <= '0;
            hi_snap_reg <= '0;
        end else begin
            if (ctl_wr) begin
                run_reg <= wr_data[0];
            end
            if (ctl_wr && wr_data[1]) begin
                tmr_reg <= '0;
            end else if (run_reg) begin
                tmr_reg <= tmr_reg + 32'd1;
            end
            if (rd_en && addr == ADDR_TMR_LO) begin
                hi_snap_reg <= tmr_reg[31:16];
            end
        end
    end

    assign tmr_lo_val  = tmr_reg[15:0];
    assign tmr_hi_val  = hi_snap_reg;
    assign tmr_ctl_val = {15'b0, run_reg};
`else
    logic unused_rd_en;

    assign unused_rd_en = rd_en;
    assign tmr_lo_val   = '0;
    assign tmr_hi_val   = '0;
    assign tmr_ctl_val  = '0;
`endif

    always_comb begin
        io_value = '0;
        case (addr)
            ADDR_LED:     io_value = DATA_W'(led_reg);
            ADDR_SW:      io_value = DATA_W'(sw_stable_reg);
            ADDR_TMR_LO:  io_value = DATA_W'(tmr_lo_val);
            ADDR_TMR_HI:  io_value = DATA_W'(tmr_hi_val);
            ADDR_TMR_CTL: io_value = DATA_W'(tmr_ctl_val);
            default:      io_value = '0;
        endcase
    end

    // I/O value is captured before this edge's writes land, matching BRAM read-first behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_ram_reg <= 1'b0;
            io_q_reg    <= '0;
        end else begin
            sel_ram_reg <= ram_sel;
            io_q_reg    <= io_value;
        end
    end

    assign rd_data = sel_ram_reg ? ram_rdata : io_q_reg;

endmodule
